// File: rtl/msk_aes_inv_rcon_pkg.sv
// Shared AES constants and the decryption round-constant state encoding.
package msk_aes_inv_rcon_pkg;

    localparam logic [7:0] RCON_DEC_INIT = 8'h36;
    localparam logic [7:0] RCON_POLY     = 8'h1b;
    localparam int         NUM_ROUNDS    = 10;
    localparam logic [3:0] ROUND_INIT    = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Division by x in GF(2^8): the exact inverse of the encryption xtime step.
    function automatic logic [7:0] rcon_div_x(input logic [7:0] rcon);
        rcon_div_x = rcon[0] ? (((rcon ^ RCON_POLY) >> 1) | 8'h80) : (rcon >> 1);
    endfunction

endpackage

// File: rtl/msk_aes_inv_rcon_mskcst.sv
// Builds a non-random d-share sharing of a public constant: share 0 = constant, rest zero.
module MSKcst #(
    parameter int d     = 2,
    parameter int count = 8
) (
    input  logic [count-1:0]   i_cst,
    output logic [count*d-1:0] o_sh_cst
);

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        o_sh_cst              = '0;
        o_sh_cst[count-1:0]   = i_cst;
    end

endmodule

// File: rtl/msk_aes_inv_rcon.sv
// Masked inverse AES round-constant generator: steps 0x36 back to 0x01 for the decryption key schedule.
module msk_aes_inv_rcon
    import msk_aes_inv_rcon_pkg::*;
#(
    parameter int d = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_init,
    input  logic           i_update,
    input  logic           i_mask_rcon,
    output logic [8*d-1:0] o_sh_rcon,
    output logic [3:0]     o_round,
    output logic           o_busy,
    output logic           o_last_round,
    output logic           o_done
);

    state_t     r_state;
    logic [7:0] r_rcon;
    logic [3:0] r_round;

    state_t     w_state_nxt;
    logic [7:0] w_rcon_nxt;
    logic [3:0] w_round_nxt;
    logic [7:0] w_rcon_gated;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_rcon  <= RCON_DEC_INIT;
            r_round <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_rcon  <= w_rcon_nxt;
            r_round <= w_round_nxt;
        end
    end

    // init outranks update; update only advances the schedule while running.
    always_comb begin
        w_state_nxt = r_state;
        w_rcon_nxt  = r_rcon;
        w_round_nxt = r_round;
        if (i_init) begin
            w_state_nxt = ST_RUN;
            w_rcon_nxt  = RCON_DEC_INIT;
            w_round_nxt = ROUND_INIT;
        end else if (i_update && (r_state == ST_RUN)) begin
            w_rcon_nxt = rcon_div_x(r_rcon);
            if (r_round == 4'd1) begin
                w_round_nxt = 4'd0;
                w_state_nxt = ST_DONE;
            end else begin
                w_round_nxt = r_round - 4'd1;
            end
        end
    end

    assign o_round      = r_round;
    assign o_busy       = (r_state == ST_RUN);
    assign o_last_round = (r_state == ST_RUN) && (r_round == 4'd1);
    assign o_done       = (r_state == ST_DONE);

    // The register keeps its value; only the presented constant is gated.
    assign w_rcon_gated = r_rcon & {8{i_mask_rcon}};

    MSKcst #(
        .d     (d),
        .count (8)
    ) u_cst (
        .i_cst    (w_rcon_gated),
        .o_sh_cst (o_sh_rcon)
    );

endmodule
